product_accumulator: RTL and testbench



---
 rtl/product_accumulator_pkg.sv | 15 +
 rtl/product_accumulator.sv | 132 +++++++++++++
 tb/tb_product_accumulator.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the multiply-accumulate path: product width and
// default accumulator geometry, plus the accumulator FSM state encoding.
package product_accumulator_pkg;

   localparam int PROD_W        = 8;
   localparam int ACC_W_DEFAULT = 16;
   localparam int CNT_W_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_e;

endpackage

// File: rtl/product_accumulator.sv
// Streams multiplier products over valid/ready and sums a burst of 1..2^CNT_W
// beats into a wide accumulator, presenting the registered sum and a sticky overflow.
module product_accumulator #(
   parameter int PROD_W = product_accumulator_pkg::PROD_W,
   parameter int ACC_W  = product_accumulator_pkg::ACC_W_DEFAULT,
   parameter int CNT_W  = product_accumulator_pkg::CNT_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  len,
   input  logic              clear,
   input  logic [PROD_W-1:0] prod,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ACC_W-1:0]  sum,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              overflow,
   output logic              busy
);

   import product_accumulator_pkg::*;

   // The counter carries one extra bit so len==0 can load the full 2^CNT_W burst.
   localparam logic [CNT_W:0] CNT_ONE = {{CNT_W{1'b0}}, 1'b1};
   localparam logic [CNT_W:0] CNT_MAX = {1'b1, {CNT_W{1'b0}}};

   state_e             state_r;
   logic [ACC_W-1:0]   acc_r;
   logic [ACC_W-1:0]   sum_r;
   logic [CNT_W:0]     count_r;
   logic               overflow_r;
   logic               out_valid_r;
   logic               in_ready_r;
   logic               busy_r;

   logic [ACC_W:0]     acc_next_s;
   logic [CNT_W:0]     len_load_s;
   logic               beat_s;
   logic               last_s;

   // Next accumulator value with carry-out, beat qualification and burst-length decode.
   always_comb begin
      acc_next_s = {1'b0, acc_r} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
      beat_s     = in_valid & in_ready_r;
      last_s     = (count_r == CNT_ONE);
      if (len == {CNT_W{1'b0}}) begin
         len_load_s = CNT_MAX;
      end else begin
         len_load_s = {1'b0, len};
      end
   end

   // Burst FSM with accumulator, beat counter and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         acc_r       <= {ACC_W{1'b0}};
         sum_r       <= {ACC_W{1'b0}};
         count_r     <= {(CNT_W + 1){1'b0}};
         overflow_r  <= 1'b0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b0;
         busy_r      <= 1'b0;
      end else if (clear) begin
         state_r     <= IDLE;
         acc_r       <= {ACC_W{1'b0}};
         sum_r       <= {ACC_W{1'b0}};
         count_r     <= {(CNT_W + 1){1'b0}};
         overflow_r  <= 1'b0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_r    <= ACCUM;
                  acc_r      <= {ACC_W{1'b0}};
                  overflow_r <= 1'b0;
                  count_r    <= len_load_s;
                  in_ready_r <= 1'b1;
                  busy_r     <= 1'b1;
               end
            end
            ACCUM: begin
               if (beat_s) begin
                  acc_r      <= acc_next_s[ACC_W-1:0];
                  overflow_r <= overflow_r | acc_next_s[ACC_W];
                  count_r    <= count_r - CNT_ONE;
                  if (last_s) begin
                     sum_r       <= acc_next_s[ACC_W-1:0];
                     out_valid_r <= 1'b1;
                     in_ready_r  <= 1'b0;
                     state_r     <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  // A start coinciding with the hand-off chains straight into the next burst.
                  if (start) begin
                     state_r    <= ACCUM;
                     acc_r      <= {ACC_W{1'b0}};
                     overflow_r <= 1'b0;
                     count_r    <= len_load_s;
                     in_ready_r <= 1'b1;
                  end else begin
                     state_r <= IDLE;
                     busy_r  <= 1'b0;
                  end
               end
            end
            default: begin
               state_r     <= IDLE;
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign sum       = sum_r;
   assign out_valid = out_valid_r;
   assign overflow  = overflow_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench: two accumulator widths driven in lockstep, compared against
// a burst-total model (sum modulo 2^ACC_W, overflow when the total reaches 2^ACC_W).
module tb_product_accumulator;
   import product_accumulator_pkg::*;

   localparam int CNT_W = CNT_W_DEFAULT;
   localparam int ACC_A = ACC_W_DEFAULT;
   localparam int ACC_B = 11;
   localparam int MOD_A = 1 << ACC_A;
   localparam int MOD_B = 1 << ACC_B;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              clear = 1'b0;
   logic              in_valid = 1'b0;
   logic              out_ready = 1'b0;
   logic [CNT_W-1:0]  len = '0;
   logic [PROD_W-1:0] prod = '0;

   logic              in_ready_a, out_valid_a, overflow_a, busy_a;
   logic [ACC_A-1:0]  sum_a;
   logic              in_ready_b, out_valid_b, overflow_b, busy_b;
   logic [ACC_B-1:0]  sum_b;

   int n_checks = 0;
   int n_pass = 0;
   int exp_left = 0;
   int exp_total = 0;
   int vq[$];

   always #5 clk = ~clk;

   product_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_A), .CNT_W(CNT_W)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .clear(clear),
      .prod(prod), .in_valid(in_valid), .in_ready(in_ready_a), .sum(sum_a),
      .out_valid(out_valid_a), .out_ready(out_ready), .overflow(overflow_a), .busy(busy_a)
   );

   product_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_B), .CNT_W(CNT_W)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .clear(clear),
      .prod(prod), .in_valid(in_valid), .in_ready(in_ready_b), .sum(sum_b),
      .out_valid(out_valid_b), .out_ready(out_ready), .overflow(overflow_b), .busy(busy_b)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks = n_checks + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".sum_a"}, 32'(sum_a), 32'd0);
      check({tag, ".sum_b"}, 32'(sum_b), 32'd0);
      check({tag, ".valid"}, 32'({out_valid_a, out_valid_b}), 32'd0);
      check({tag, ".ovf"}, 32'({overflow_a, overflow_b}), 32'd0);
      check({tag, ".busy"}, 32'({busy_a, busy_b}), 32'd0);
      check({tag, ".ready"}, 32'({in_ready_a, in_ready_b}), 32'd0);
   endtask

   task automatic check_result(input string tag);
      check({tag, ".valid"}, 32'({out_valid_a, out_valid_b}), 32'd3);
      check({tag, ".sum_a"}, 32'(sum_a), 32'(exp_total % MOD_A));
      check({tag, ".ovf_a"}, 32'(overflow_a), (exp_total >= MOD_A) ? 32'd1 : 32'd0);
      check({tag, ".sum_b"}, 32'(sum_b), 32'(exp_total % MOD_B));
      check({tag, ".ovf_b"}, 32'(overflow_b), (exp_total >= MOD_B) ? 32'd1 : 32'd0);
      check({tag, ".ready"}, 32'({in_ready_a, in_ready_b}), 32'd0);
      check({tag, ".busy"}, 32'({busy_a, busy_b}), 32'd3);
   endtask

   task automatic begin_burst(input int n_len);
      len = CNT_W'(n_len);
      start = 1'b1;
      step();
      start = 1'b0;
      exp_left = (n_len == 0) ? (1 << CNT_W) : n_len;
      exp_total = 0;
      check("start.ready", 32'({in_ready_a, in_ready_b}), 32'd3);
      check("start.busy", 32'({busy_a, busy_b}), 32'd3);
      check("start.ovf", 32'({overflow_a, overflow_b}), 32'd0);
   endtask

   // mode 0: always valid, 1: valid every other cycle, 2: random stalls
   task automatic feed(input int vals[$], input int n_beats, input int mode);
      int got = 0;
      int cyc = 0;
      int idx = 0;
      bit v;
      while (got < n_beats && cyc < 200) begin
         case (mode)
            1: v = (cyc % 2 == 1);
            2: v = ($urandom_range(99) >= 30);
            default: v = 1'b1;
         endcase
         in_valid = v;
         prod = (idx < vals.size()) ? PROD_W'(vals[idx]) : PROD_W'($urandom_range(255));
         check("feed.ready", 32'({in_ready_a, in_ready_b}), 32'd3);
         step();
         if (v) begin
            exp_total = exp_total + int'(prod);
            idx = idx + 1;
            got = got + 1;
            exp_left = exp_left - 1;
         end
         cyc = cyc + 1;
      end
      in_valid = 1'b0;
      if (got < n_beats) check("feed.timeout", 32'(got), 32'(n_beats));
      if (exp_left == 0) check_result("burst");
   endtask

   task automatic release_result(input int hold_cycles, input bit restart, input int new_len);
      out_ready = 1'b0;
      for (int i = 0; i < hold_cycles; i++) begin
         in_valid = 1'b1;
         prod = PROD_W'($urandom_range(255));
         step();
         check("hold.valid", 32'(out_valid_a), 32'd1);
         check("hold.sum", 32'(sum_a), 32'(exp_total % MOD_A));
         check("hold.ready", 32'(in_ready_a), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      start = restart;
      len = CNT_W'(new_len);
      step();
      out_ready = 1'b0;
      start = 1'b0;
      check("release.valid", 32'({out_valid_a, out_valid_b}), 32'd0);
      if (restart) begin
         exp_left = (new_len == 0) ? (1 << CNT_W) : new_len;
         exp_total = 0;
         check("restart.ready", 32'({in_ready_a, in_ready_b}), 32'd3);
         check("restart.ovf", 32'({overflow_a, overflow_b}), 32'd0);
      end else begin
         check("release.busy", 32'({busy_a, busy_b}), 32'd0);
         check("release.ready", 32'({in_ready_a, in_ready_b}), 32'd0);
      end
   endtask

   initial begin
      #12;
      check_all_zero("reset");
      #1;
      rst_n = 1'b1;
      step();

      // basic 3-beat burst
      vq = {225, 1, 21};
      begin_burst(3);
      feed(vq, 3, 0);
      release_result(0, 1'b0, 0);

      // 16 beats of 225 with alternating stalls; narrow instance wraps
      vq.delete();
      for (int i = 0; i < 16; i++) vq.push_back(225);
      begin_burst(0);
      feed(vq, 16, 1);
      release_result(2, 1'b0, 0);
      vq = {1, 1};
      begin_burst(2);
      feed(vq, 2, 0);
      release_result(0, 1'b0, 0);

      // start ignored mid-burst, then backpressure and back-to-back restart
      vq.delete();
      begin_burst(4);
      start = 1'b1;
      len = CNT_W'(1);
      step();
      start = 1'b0;
      check("accum.start_ignored", 32'(in_ready_a), 32'd1);
      feed(vq, 4, 2);
      release_result(5, 1'b1, 1);
      vq = {9};
      feed(vq, 1, 0);
      release_result(0, 1'b0, 0);

      // abort after 2 of 4 beats; beat presented with clear is dropped
      vq.delete();
      begin_burst(4);
      feed(vq, 2, 0);
      clear = 1'b1;
      in_valid = 1'b1;
      prod = PROD_W'(50);
      step();
      clear = 1'b0;
      in_valid = 1'b0;
      check_all_zero("abort");
      vq = {4};
      begin_burst(1);
      feed(vq, 1, 0);
      release_result(0, 1'b0, 0);

      // random bursts with random stalls and holds
      vq.delete();
      for (int b = 0; b < 6; b++) begin
         begin_burst(int'($urandom_range(15)));
         feed(vq, exp_left, 2);
         release_result(int'($urandom_range(3)), 1'b0, 0);
      end

      // asynchronous reset mid-burst
      vq = {200, 100};
      begin_burst(5);
      feed(vq, 2, 0);
      #3;
      rst_n = 1'b0;
      #1;
      check_all_zero("rst_async");
      start = 1'b1;
      len = CNT_W'(2);
      step();
      step();
      check("rst_hold.busy", 32'({busy_a, busy_b}), 32'd0);
      check("rst_hold.ready", 32'({in_ready_a, in_ready_b}), 32'd0);
      start = 1'b0;
      rst_n = 1'b1;
      step();
      check_all_zero("post_rst");
      vq.delete();
      begin_burst(2);
      feed(vq, 2, 0);
      release_result(1, 1'b0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
